delay_line_sequencer: RTL and testbench

- Sequences the sample memory for the delay/reverb/looper path, one transaction set per audio sample.
- Sits between the ADC sample input and the gain multiply stage.
- On each `adc_clock` rising edge it optionally writes the new sample at the write pointer, then reads the delayed (or looped) sample back.
- It presents that sample with a one-cycle valid strobe to the downstream gain multiplier.
- The memory is either the on-chip macro or the off-chip memory, which has a ready handshake.

---
 rtl/pedal_pkg.sv | 16 +
 rtl/delay_line_sequencer_if.sv | 22 ++
 rtl/delay_line_sequencer_adc_edge_sync.sv | 23 ++
 rtl/delay_line_sequencer.sv | 146 ++++++++++++++
 tb/tb_delay_line_sequencer.sv | 280 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pedal_pkg.sv
// Shared types and defaults for the pedal sample-memory path.
package pedal_pkg;

  localparam int unsigned DLS_DATA_W        = 16;
  localparam int unsigned DLS_ADDR_W        = 16;
  localparam int unsigned DLS_ONCHIP_RD_LAT = 1;

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    READ,
    READ_WAIT,
    DONE
  } dls_state_t;

endpackage

// File: rtl/delay_line_sequencer_if.sv
// Sample-memory bus between the delay-line sequencer and the on/off-chip memory.
interface delay_line_sequencer_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 16
);
  logic              memory_we;
  logic              mem_re;
  logic [ADDR_W-1:0] address_out;
  logic [DATA_W-1:0] data_out;
  logic [DATA_W-1:0] mem_rdata;
  logic              off_chip_mem_ready;

  modport master (
    output memory_we, mem_re, address_out, data_out,
    input  mem_rdata, off_chip_mem_ready
  );

  modport slave (
    input  memory_we, mem_re, address_out, data_out,
    output mem_rdata, off_chip_mem_ready
  );
endinterface

// File: rtl/delay_line_sequencer_adc_edge_sync.sv
// Brings adc_clock into the clk domain and emits a one-cycle pulse per rising edge.
module adc_edge_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic adc_clock,
  output logic adc_edge
);
  logic sync1, sync2, sync3;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1    <= 1'b0;
      sync2    <= 1'b0;
      sync3    <= 1'b0;
      adc_edge <= 1'b0;
    end else begin
      sync1    <= adc_clock;
      sync2    <= sync1;
      sync3    <= sync2;
      adc_edge <= sync2 & ~sync3;
    end
  end
endmodule

// File: rtl/delay_line_sequencer.sv
// Per-sample write/read sequencer for the delay, reverb and looper sample memory.
module delay_line_sequencer
  import pedal_pkg::*;
#(
  parameter int unsigned DATA_W        = DLS_DATA_W,
  parameter int unsigned ADDR_W        = DLS_ADDR_W,
  parameter int unsigned ONCHIP_RD_LAT = DLS_ONCHIP_RD_LAT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  adc_clock,
  input  logic                  record,
  input  logic                  loop,
  input  logic                  off_chip_mem,
  input  logic [15:0]           delay_reverb,
  input  logic [DATA_W-1:0]     data_in,
  delay_line_sequencer_if.master mem,
  output logic [DATA_W-1:0]     sample_out,
  output logic                  sample_valid,
  output logic                  overrun,
  output logic                  busy
);

  dls_state_t state, next_state;

  logic              adc_edge;
  logic [DATA_W-1:0] sample_q;
  logic              rec_q, loop_q, loop_prev;
  logic [15:0]       dly_q;
  logic [ADDR_W-1:0] wr_ptr, play_ptr, loop_base;
  logic [15:0]       play_cnt;
  logic [7:0]        lat_cnt;
  logic [ADDR_W-1:0] addr_hold, addr_c;
  logic [DATA_W-1:0] data_hold, data_c;
  logic              we_c, re_c, rd_done;
  logic [ADDR_W-1:0] entry_ptr;

  adc_edge_sync u_sync (
    .clk       (clk),
    .rst_n     (rst_n),
    .adc_clock (adc_clock),
    .adc_edge  (adc_edge)
  );

  assign entry_ptr = wr_ptr - ADDR_W'(delay_reverb);

  always_comb begin
    next_state = state;
    we_c       = 1'b0;
    re_c       = 1'b0;
    addr_c     = addr_hold;
    data_c     = data_hold;
    rd_done    = 1'b0;
    case (state)
      IDLE: begin
        if (adc_edge) next_state = (record && !loop) ? WRITE : READ;
      end
      WRITE: begin
        we_c   = 1'b1;
        addr_c = wr_ptr;
        data_c = sample_q;
        if (!off_chip_mem || mem.off_chip_mem_ready) next_state = READ;
      end
      READ: begin
        re_c       = 1'b1;
        addr_c     = loop_q ? play_ptr : (wr_ptr - ADDR_W'(dly_q));
        next_state = READ_WAIT;
      end
      READ_WAIT: begin
        if (off_chip_mem ? mem.off_chip_mem_ready
                         : (lat_cnt == 8'(ONCHIP_RD_LAT - 1))) begin
          rd_done    = 1'b1;
          next_state = DONE;
        end
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  assign mem.memory_we   = we_c;
  assign mem.mem_re      = re_c;
  assign mem.address_out = addr_c;
  assign mem.data_out    = data_c;
  assign sample_valid    = (state == DONE);
  assign busy            = (state != IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      sample_q   <= '0;
      rec_q      <= 1'b0;
      loop_q     <= 1'b0;
      loop_prev  <= 1'b0;
      dly_q      <= '0;
      wr_ptr     <= '0;
      play_ptr   <= '0;
      loop_base  <= '0;
      play_cnt   <= '0;
      lat_cnt    <= '0;
      addr_hold  <= '0;
      data_hold  <= '0;
      sample_out <= '0;
      overrun    <= 1'b0;
    end else begin
      state     <= next_state;
      addr_hold <= addr_c;
      data_hold <= data_c;

      if (adc_edge && state != IDLE) overrun <= 1'b1;

      if (state == IDLE && adc_edge) begin
        sample_q  <= data_in;
        rec_q     <= record && !loop;
        loop_q    <= loop;
        dly_q     <= delay_reverb;
        loop_prev <= loop;
        if (loop && !loop_prev) begin
          loop_base <= entry_ptr;
          play_ptr  <= entry_ptr;
          play_cnt  <= '0;
        end
      end

      lat_cnt <= (state == READ_WAIT) ? lat_cnt + 8'd1 : 8'd0;

      if (rd_done) sample_out <= mem.mem_rdata;

      // play_cnt is the offset into the loop; play_ptr tracks loop_base + play_cnt
      // so playback restarts at the loop start once the offset reaches the loop length.
      if (state == DONE) begin
        if (rec_q) wr_ptr <= wr_ptr + ADDR_W'(1);
        if (loop_q) begin
          if (({1'b0, play_cnt} + 17'd1) >= {1'b0, dly_q}) begin
            play_cnt <= '0;
            play_ptr <= loop_base;
          end else begin
            play_cnt <= play_cnt + 16'd1;
            play_ptr <= play_ptr + ADDR_W'(1);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_delay_line_sequencer.sv
// Scoreboard bench for delay_line_sequencer against on-chip and off-chip memory models.
module tb_delay_line_sequencer;
  import pedal_pkg::*;

  // 8-bit addressing keeps the pointer-wrap scenario within a short run.
  localparam int unsigned DW = 16;
  localparam int unsigned AW = 8;

  logic          clk = 1'b0, rst_n = 1'b0, adc_clock = 1'b0;
  logic          record = 1'b0, loop = 1'b0, off_chip_mem = 1'b0;
  logic [15:0]   delay_reverb = '0;
  logic [DW-1:0] data_in = '0;
  logic [DW-1:0] sample_out;
  logic          sample_valid, overrun, busy;

  delay_line_sequencer_if #(.DATA_W(DW), .ADDR_W(AW)) mem_if ();

  delay_line_sequencer #(.DATA_W(DW), .ADDR_W(AW), .ONCHIP_RD_LAT(1)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .adc_clock    (adc_clock),
    .record       (record),
    .loop         (loop),
    .off_chip_mem (off_chip_mem),
    .delay_reverb (delay_reverb),
    .data_in      (data_in),
    .mem          (mem_if),
    .sample_out   (sample_out),
    .sample_valid (sample_valid),
    .overrun      (overrun),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  // Memory models
  logic [DW-1:0] mem [256] = '{default: '0};
  logic [DW-1:0] onchip_rdata = '0, oc_rdata = '0, oc_data = '0;
  logic          oc_ready = 1'b0, oc_hang = 1'b0, oc_wr = 1'b0;
  logic [AW-1:0] oc_addr = '0;
  int unsigned   oc_cnt = 0;

  always @(posedge clk) begin
    if (!off_chip_mem) begin
      if (mem_if.memory_we) mem[mem_if.address_out] <= mem_if.data_out;
      if (mem_if.mem_re)    onchip_rdata <= mem[mem_if.address_out];
    end
    oc_ready <= 1'b0;
    if (!rst_n) begin
      oc_cnt <= 0;
    end else if (oc_cnt != 0) begin
      oc_cnt <= oc_cnt - 1;
      if (oc_cnt == 1 && !oc_hang) begin
        oc_ready <= 1'b1;
        if (oc_wr) mem[oc_addr] <= oc_data;
        else       oc_rdata     <= mem[oc_addr];
      end
    end else if (off_chip_mem && (mem_if.memory_we || mem_if.mem_re) && !oc_ready) begin
      oc_cnt  <= 5;
      oc_wr   <= mem_if.memory_we;
      oc_addr <= mem_if.address_out;
      oc_data <= mem_if.data_out;
    end
  end

  assign mem_if.mem_rdata          = off_chip_mem ? oc_rdata : onchip_rdata;
  assign mem_if.off_chip_mem_ready = oc_ready;

  // Scoreboard
  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wr_t;

  wr_t           exp_wr[$];
  logic [AW-1:0] exp_rd[$];
  logic [DW-1:0] exp_smp[$];
  int            vectors = 0, miscompares = 0;
  wr_t           w_pop;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  task automatic flag(input string name, input logic [31:0] act);
    vectors++;
    miscompares++;
    $display("FAIL %s: got 0x%0h, expected no such event", name, act);
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (mem_if.memory_we && mem_if.mem_re) flag("we_re_overlap", {mem_if.memory_we, mem_if.mem_re});
      if (mem_if.memory_we && (!off_chip_mem || mem_if.off_chip_mem_ready)) begin
        if (exp_wr.size() == 0) flag("unexpected_write", mem_if.address_out);
        else begin
          w_pop = exp_wr.pop_front();
          check("write_addr", mem_if.address_out, w_pop.a);
          check("write_data", mem_if.data_out, w_pop.d);
        end
      end
      if (mem_if.mem_re) begin
        if (exp_rd.size() == 0) flag("unexpected_read", mem_if.address_out);
        else check("read_addr", mem_if.address_out, exp_rd.pop_front());
      end
      if (sample_valid) begin
        if (exp_smp.size() == 0) flag("unexpected_valid", sample_out);
        else check("sample_out", sample_out, exp_smp.pop_front());
      end
    end
  end

  // Stimulus helpers
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_txn(input logic do_wr, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                            input logic [AW-1:0] ra, input logic [DW-1:0] s);
    wr_t w;
    if (do_wr) begin
      w.a = wa;
      w.d = wd;
      exp_wr.push_back(w);
    end
    exp_rd.push_back(ra);
    exp_smp.push_back(s);
  endtask

  task automatic adc_pulse();
    adc_clock = 1'b1;
    step(4);
    adc_clock = 1'b0;
    step(4);
  endtask

  task automatic wait_idle(input int maxc);
    int c = 0;
    while (busy && c < maxc) begin
      step(1);
      c++;
    end
    if (busy) flag("busy_timeout", c);
  endtask

  task automatic do_sample(input logic [DW-1:0] d, input logic rec, input logic lp, input logic [15:0] dly);
    data_in      = d;
    record       = rec;
    loop         = lp;
    delay_reverb = dly;
    adc_pulse();
    wait_idle(100);
    step(4);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_we"},       mem_if.memory_we,   0);
    check({tag, "_re"},       mem_if.mem_re,      0);
    check({tag, "_addr"},     mem_if.address_out, 0);
    check({tag, "_wdata"},    mem_if.data_out,    0);
    check({tag, "_sample"},   sample_out,         0);
    check({tag, "_valid"},    sample_valid,       0);
    check({tag, "_overrun"},  overrun,            0);
    check({tag, "_busy"},     busy,               0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;

    // Reset state
    rst_n = 1'b0;
    step(3);
    check_zero("reset");
    rst_n = 1'b1;
    step(2);

    // Ramp with delay 4: first four reads hit the cleared memory
    for (int i = 1; i <= 8; i++)
      expect_txn(1'b1, AW'(i - 1), DW'(i), AW'(i - 5), (i <= 4) ? DW'(0) : DW'(i - 4));
    for (int i = 1; i <= 8; i++) do_sample(DW'(i), 1'b1, 1'b0, 16'd4);

    // Zero delay bypass
    expect_txn(1'b1, 8'h08, 16'h1234, 8'h08, 16'h1234);
    do_sample(16'h1234, 1'b1, 1'b0, 16'd0);

    // Fill up to 0xFD so the write pointer reaches 0xFE
    for (int a = 9; a <= 'hFD; a++) begin
      expect_txn(1'b1, AW'(a), 16'h5500 | DW'(a), AW'(a), 16'h5500 | DW'(a));
      do_sample(16'h5500 | DW'(a), 1'b1, 1'b0, 16'd0);
    end

    // Pointer wrap with delay 3
    expect_txn(1'b1, 8'hFE, 16'h00A0, 8'hFB, 16'h55FB);
    do_sample(16'h00A0, 1'b1, 1'b0, 16'd3);
    expect_txn(1'b1, 8'hFF, 16'h00A1, 8'hFC, 16'h55FC);
    do_sample(16'h00A1, 1'b1, 1'b0, 16'd3);
    expect_txn(1'b1, 8'h00, 16'h00A2, 8'hFD, 16'h55FD);
    do_sample(16'h00A2, 1'b1, 1'b0, 16'd3);

    // Looper: record 0x10..0x17 at 0..7, then loop the last four samples
    rst_n = 1'b0;
    step(2);
    rst_n = 1'b1;
    step(2);
    for (int i = 0; i < 8; i++) begin
      expect_txn(1'b1, AW'(i), 16'h0010 + DW'(i), AW'(i), 16'h0010 + DW'(i));
      do_sample(16'h0010 + DW'(i), 1'b1, 1'b0, 16'd0);
    end
    for (int k = 0; k < 6; k++) begin
      expect_txn(1'b0, '0, '0, AW'(4 + (k % 4)), 16'h0014 + DW'(k % 4));
      do_sample(16'h00EE, 1'b1, 1'b1, 16'd4);
    end

    // Off-chip with a second adc edge landing during READ_WAIT
    off_chip_mem = 1'b1;
    expect_txn(1'b1, 8'h08, 16'h7777, 8'h08, 16'h7777);
    data_in      = 16'h7777;
    record       = 1'b1;
    loop         = 1'b0;
    delay_reverb = 16'd0;
    adc_pulse();
    c = 0;
    while (!mem_if.mem_re && c < 100) begin
      step(1);
      c++;
    end
    if (!mem_if.mem_re) flag("read_timeout", c);
    data_in = 16'h8888;
    adc_pulse();
    wait_idle(100);
    step(4);
    check("overrun_set", overrun, 1);
    expect_txn(1'b1, 8'h09, 16'h9999, 8'h09, 16'h9999);
    do_sample(16'h9999, 1'b1, 1'b0, 16'd0);
    check("overrun_sticky", overrun, 1);

    // Reset while an off-chip write is stalled
    oc_hang = 1'b1;
    data_in = 16'h4242;
    adc_clock = 1'b1;
    step(4);
    adc_clock = 1'b0;
    c = 0;
    while (!mem_if.memory_we && c < 20) begin
      step(1);
      c++;
    end
    if (!mem_if.memory_we) flag("write_timeout", c);
    step(2);
    rst_n = 1'b0;
    step(1);
    check_zero("abort");
    rst_n        = 1'b1;
    oc_hang      = 1'b0;
    off_chip_mem = 1'b0;
    step(3);
    expect_txn(1'b1, 8'h00, 16'h5151, 8'h00, 16'h5151);
    do_sample(16'h5151, 1'b1, 1'b0, 16'd0);

    step(5);
    check("pending_writes", exp_wr.size(), 0);
    check("pending_reads",  exp_rd.size(), 0);
    check("pending_samples", exp_smp.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
